stopwatch_bcd_counter: RTL

STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_bcd_counter_bcd_digit.sv | 32 +++
 rtl/stopwatch_bcd_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM encodings, default dividers and BCD limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  localparam int TICK_DIV_DEF = 32'd1000000;
  localparam int SCAN_DIV_DEF = 32'd100000;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_at_max(input logic [3:0] d);
    return (d == BCD_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// Single BCD digit (0..9) with ripple carry; clear has priority over counting.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic       carry_in,
  output logic [3:0] q,
  output logic       carry_out
);

  logic [3:0] q_r;

  assign carry_out = carry_in & bcd_at_max(q_r);
  assign q         = q_r;

  // Digit register: zero on clear, advance when enabled and carried into.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= 4'd0;
    end else if (clear) begin
      q_r <= 4'd0;
    end else if (inc && carry_in) begin
      q_r <= bcd_at_max(q_r) ? 4'd0 : (q_r + 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch with 4-digit BCD time, run/pause FSM and a digit-scan strobe.
// Define STOPWATCH_SAT_EN to saturate at 99.99 (and pause) instead of wrapping.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  output logic [15:0] cntr,
  output logic        dispen,
  output logic        running,
  output logic        wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
`ifdef STOPWATCH_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  sw_state_t     state_r;
  logic          running_r;
  logic          prev_ss_r;
  logic [TW-1:0] tick_cnt_r;
  logic [SW-1:0] scan_cnt_r;
  logic          dispen_r;
  logic          wrap_r;
  logic          edge_s;
  logic          tick_s;
  logic          at_max_s;
  logic          inc_s;
  logic [4:0]    carry_s;

  assign edge_s  = start_stop & ~prev_ss_r;
  assign tick_s  = (state_r == ST_RUN) && (tick_cnt_r == TICK_LAST);
  // With saturation the final tick is swallowed so the display holds 99.99.
  assign inc_s   = tick_s & ~(SAT_EN & at_max_s);
  assign carry_s[0] = 1'b1;
  assign at_max_s   = carry_s[4];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .inc       (inc_s),
      .carry_in  (carry_s[i]),
      .q         (cntr[4*i +: 4]),
      .carry_out (carry_s[i+1])
    );
  end

  // Previous start_stop level; resets high so a held button gives no edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_ss_r <= 1'b1;
    end else begin
      prev_ss_r <= start_stop;
    end
  end

  // Run/pause FSM; clear overrides everything, a tick is applied before an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else if (clear) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (edge_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (edge_s || (SAT_EN && tick_s && at_max_s)) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (edge_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Tick prescaler: counts in RUN, holds in PAUSE, zeroed in IDLE or on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (clear || (state_r == ST_IDLE)) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_RUN) begin
      tick_cnt_r <= tick_s ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // Free-running scan prescaler and its one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= {SW{1'b0}};
      dispen_r   <= 1'b0;
    end else begin
      scan_cnt_r <= (scan_cnt_r == SCAN_LAST) ? {SW{1'b0}} : (scan_cnt_r + SW'(1));
      dispen_r   <= (scan_cnt_r == SCAN_LAST);
    end
  end

  // Rollover pulse, suppressed when clear zeroes the count anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tick_s & at_max_s & ~clear & ~SAT_EN;
    end
  end

  assign dispen  = dispen_r;
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule
